// File: rtl/yarp_pkg.sv
// yarp_pkg: shared types and constants for the yarp core memory path.
//   arb_state_t       - memory arbiter FSM states
//   arb_owner_t       - which core port owns the current bus transaction
//   BYTE_EN_*         - access-size encoding used on byte_en buses
//   ARB_TIMEOUT_RDATA - read data returned when a bus response times out
package yarp_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  localparam logic [1:0]  BYTE_EN_BYTE = 2'b00;
  localparam logic [1:0]  BYTE_EN_HALF = 2'b01;
  localparam logic [1:0]  BYTE_EN_WORD = 2'b11;

  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter: shares one memory bus between the instruction-fetch and
// data-memory ports of the yarp core. One transaction outstanding at a time;
// data has priority, but after STARVE_LIMIT consecutive data selections made
// while fetch is waiting, fetch wins the next arbitration.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_req_i/imem_addr_i -> imem_gnt_o/imem_rvalid_o/imem_rdata_o
//   dmem_req_i/addr/byte_en/wr/wr_data -> dmem_gnt_o/dmem_rvalid_o/dmem_rdata_o
//   bus_req_o/addr/byte_en/wr/wr_data  <- bus_gnt_i/bus_rvalid_i/bus_rdata_i
//   err_o: sticky response-timeout flag
//
// Build option: define YARP_ARB_TIMEOUT_EN to enable the response watchdog
// (TIMEOUT_CYCLES). Without it err_o is tied low and ARB_RSP waits forever.
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,
  input  logic        dmem_req_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [1:0]  dmem_byte_en_i,
  input  logic        dmem_wr_i,
  input  logic [31:0] dmem_wr_data_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic [1:0]  bus_byte_en_o,
  output logic        bus_wr_o,
  output logic [31:0] bus_wr_data_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t  r_state;
  arb_owner_t  r_owner;
  logic [31:0] r_addr;
  logic [1:0]  r_byte_en;
  logic        r_wr;
  logic [31:0] r_wr_data;
  logic [3:0]  r_starve_cnt;

  logic        w_any_req;
  logic        w_sel_data;
  logic        w_owner_data;
  logic        w_timeout;
  logic        w_rsp_done;
  logic [31:0] w_rsp_data;

  assign w_any_req  = imem_req_i | dmem_req_i;
  // Data wins whenever it requests, except when fetch is waiting and starved.
  assign w_sel_data = dmem_req_i & ~(imem_req_i & (r_starve_cnt == STARVE_MAX));

  assign w_owner_data = (r_owner == OWN_DATA);

`ifdef YARP_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_to_cnt;
  logic       r_err;

  // r_to_cnt counts completed ARB_RSP cycles; the TIMEOUT_CYCLES-th RSP cycle
  // without a response terminates the transaction.
  assign w_timeout = (r_state == ARB_RSP) && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ARB_REQ && bus_gnt_i) begin
        r_to_cnt <= 8'd0;
      end else if (r_state == ARB_RSP) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
      // A real response in the limit cycle wins over the timeout.
      if (w_timeout && !bus_rvalid_i) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
  assign err_o        = 1'b0;
`endif

  assign w_rsp_done = (r_state == ARB_RSP) & (bus_rvalid_i | w_timeout);
  assign w_rsp_data = bus_rvalid_i ? bus_rdata_i : ARB_TIMEOUT_RDATA;

  // Grants and response strobes are combinational so the requester sees them
  // in the same cycle as the bus handshake.
  assign imem_gnt_o    = (r_state == ARB_REQ) & bus_gnt_i & ~w_owner_data;
  assign dmem_gnt_o    = (r_state == ARB_REQ) & bus_gnt_i &  w_owner_data;
  assign imem_rvalid_o = w_rsp_done & ~w_owner_data;
  assign dmem_rvalid_o = w_rsp_done &  w_owner_data;
  assign imem_rdata_o  = imem_rvalid_o ? w_rsp_data : 32'd0;
  assign dmem_rdata_o  = dmem_rvalid_o ? w_rsp_data : 32'd0;

  assign bus_req_o     = (r_state == ARB_REQ);
  assign bus_addr_o    = r_addr;
  assign bus_byte_en_o = r_byte_en;
  assign bus_wr_o      = r_wr;
  assign bus_wr_data_o = r_wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_INSTR;
      r_addr       <= 32'd0;
      r_byte_en    <= 2'd0;
      r_wr         <= 1'b0;
      r_wr_data    <= 32'd0;
      r_starve_cnt <= 4'd0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_state   <= ARB_REQ;
            r_owner   <= w_sel_data ? OWN_DATA : OWN_INSTR;
            r_addr    <= w_sel_data ? dmem_addr_i : imem_addr_i;
            r_byte_en <= w_sel_data ? dmem_byte_en_i : BYTE_EN_WORD;
            r_wr      <= w_sel_data & dmem_wr_i;
            r_wr_data <= w_sel_data ? dmem_wr_data_i : 32'd0;
          end
          if (!imem_req_i) begin
            r_starve_cnt <= 4'd0;
          end else if (w_sel_data) begin
            if (r_starve_cnt != STARVE_MAX) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end else begin
            r_starve_cnt <= 4'd0;
          end
        end
        ARB_REQ: begin
          if (bus_gnt_i) begin
            r_state <= ARB_RSP;
          end
        end
        ARB_RSP: begin
          if (w_rsp_done) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
